spi_cfg_master: RTL and testbench

Command-driven SPI master that generates `sck`/`ss`/`mosi` and samples `miso` for control-port register access on the converter boards (DSD1792A-style serial control). It sits directly upstream of the board's SPI slaves. It converts one accepted register command into one framed SPI transaction: a read/write flag, then address, then data, MSB first. For reads it returns the captured register value on a one-cycle response strobe.

---
 rtl/spi_cfg_master.sv | 180 ++++++++++++++++++
 tb/tb_spi_cfg_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// Mode-0 SPI master for register-style serial control ports: one accepted command becomes one
// frame {rw, addr, data} sent MSB first; reads return the captured data on a one-cycle strobe.
module spi_cfg_master #(
  parameter int sclk_div      = 4,
  parameter int ss_gap        = 4,
  parameter int max_addr_bits = 16,
  parameter int max_data_bits = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_read,
  input  logic [max_addr_bits-1:0] cmd_addr,
  input  logic [max_data_bits-1:0] cmd_data,
  input  logic [4:0]               addr_bits,
  input  logic [4:0]               data_bits,
  output logic                     rsp_valid,
  output logic [max_data_bits-1:0] rsp_data,
  output logic                     busy,
  output logic                     sck,
  output logic                     ss,
  output logic                     mosi,
  input  logic                     miso
);

  localparam int CNT_MAX = (sclk_div > ss_gap) ? sclk_div : ss_gap;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(sclk_div - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(ss_gap - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CNT_W-1:0]         r_cnt;

  logic                     w_accept;
  logic                     w_phase_done;
  logic                     w_gap_done;
  logic                     w_to_high;
  logic [5:0]               w_a;
  logic [5:0]               w_dn;
  logic [5:0]               w_n;
  logic [31:0]              w_addr_field;
  logic [31:0]              w_data_field;
  logic [31:0]              w_frame;

  logic                     r_read;
  logic [5:0]               r_a;
  logic [5:0]               r_n;
  logic [5:0]               r_rise_cnt;
  logic [31:0]              r_shift;
  logic                     r_mosi;
  logic [max_data_bits-1:0] r_rx;
  logic [max_data_bits-1:0] r_rsp_data;
  logic                     r_rsp_valid;

  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_phase_done = (r_cnt == PHASE_LAST);
  assign w_gap_done   = (r_cnt == GAP_LAST);
  assign w_to_high    = (w_state_next == S_HIGH) && (r_state != S_HIGH);

  // Lengths are clamped once at accept; everything downstream trusts r_a / r_n.
  assign w_a  = (addr_bits < 5'd2) ? 6'd2 : (addr_bits > 5'd16) ? 6'd16 : {1'b0, addr_bits};
  assign w_dn = (data_bits < 5'd1) ? 6'd1 : (data_bits > 5'd16) ? 6'd16 : {1'b0, data_bits};
  assign w_n  = w_a + w_dn;

  assign w_addr_field = 32'(cmd_addr) & ((32'd1 << (w_a - 6'd1)) - 32'd1);
  assign w_data_field = cmd_read ? 32'd0 : (32'(cmd_data) & ((32'd1 << w_dn) - 32'd1));

  // Frame built right-aligned, then left-aligned so bit 1 sits at [31].
  assign w_frame = (({31'd0, cmd_read} << (w_n - 6'd1))
                   | (w_addr_field << w_dn)
                   | w_data_field) << (6'd32 - w_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_next = S_SETUP;
      S_SETUP: if (w_phase_done) w_state_next = S_HIGH;
      S_HIGH:  if (w_phase_done) w_state_next = (r_rise_cnt == r_n) ? S_HOLD : S_LOW;
      S_LOW:   if (w_phase_done) w_state_next = S_HIGH;
      S_HOLD:  if (w_phase_done) w_state_next = S_GAP;
      S_GAP:   if (w_gap_done)   w_state_next = S_IDLE;
      default:                   w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset forces them immediately.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    ss        = 1'b0;
    sck       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        ss        = 1'b1;
      end
      S_HIGH:  sck = 1'b1;
      S_GAP:   ss  = 1'b1;
      default: ;
    endcase
  end

  assign mosi      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read      <= 1'b0;
      r_a         <= 6'd0;
      r_n         <= 6'd0;
      r_rise_cnt  <= 6'd0;
      r_shift     <= 32'd0;
      r_mosi      <= 1'b0;
      r_rx        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_read     <= cmd_read;
        r_a        <= w_a;
        r_n        <= w_n;
        r_mosi     <= w_frame[31];
        r_shift    <= {w_frame[30:0], 1'b0};
        r_rise_cnt <= 6'd0;
        r_rx       <= '0;
      end
      // miso is captured on the edge that raises sck, only for the data-phase bits.
      if (w_to_high) begin
        r_rise_cnt <= r_rise_cnt + 6'd1;
        if (r_rise_cnt >= r_a) begin
          r_rx <= {r_rx[max_data_bits-2:0], miso};
        end
      end
      if ((r_state == S_HIGH) && (w_state_next == S_LOW)) begin
        r_mosi  <= r_shift[31];
        r_shift <= {r_shift[30:0], 1'b0};
      end
      if ((r_state == S_HIGH) && (w_state_next == S_HOLD)) begin
        r_mosi <= 1'b0;
      end
      if ((r_state == S_HOLD) && (w_state_next == S_GAP) && r_read) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_rx;
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: a D=4 instance with a mode-0 slave register model,
// plus a D=1 instance for length clamping and half-rate sck.
module tb_spi_cfg_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid0 = 1'b0;
  logic        cmd_valid1 = 1'b0;
  logic        cmd_read = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [15:0] cmd_data = 16'd0;
  logic [4:0]  addr_bits = 5'd8;
  logic [4:0]  data_bits = 5'd8;

  logic        cmd_ready0, rsp_valid0, busy0, sck0, ss0, mosi0;
  logic [15:0] rsp_data0;
  logic        miso0 = 1'b0;
  logic        cmd_ready1, rsp_valid1, busy1, sck1, ss1, mosi1;
  logic [15:0] rsp_data1;
  logic        miso1 = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_cfg_master #(.sclk_div(4), .ss_gap(4), .max_addr_bits(16), .max_data_bits(16)) dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .addr_bits(addr_bits), .data_bits(data_bits), .rsp_valid(rsp_valid0),
    .rsp_data(rsp_data0), .busy(busy0), .sck(sck0), .ss(ss0), .mosi(mosi0), .miso(miso0)
  );

  spi_cfg_master #(.sclk_div(1), .ss_gap(4), .max_addr_bits(16), .max_data_bits(16)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .addr_bits(addr_bits), .data_bits(data_bits), .rsp_valid(rsp_valid1),
    .rsp_data(rsp_data1), .busy(busy1), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );

  // Mode-0 slave model for dut0: samples on sck rise, drives on sck fall.
  int          cfg_a = 8;
  int          cfg_dn = 8;
  logic [31:0] sl_frame = 32'd0;
  int          sl_cnt = 0;
  logic [15:0] sl_rdata = 16'd0;
  logic [15:0] sl_regs [int];

  always @(negedge ss0) begin
    sl_cnt   = 0;
    sl_frame = 32'd0;
  end

  always @(posedge sck0) begin
    if (!ss0) begin
      sl_frame = {sl_frame[30:0], mosi0};
      sl_cnt++;
    end
  end

  always @(negedge sck0) begin : slave_drive
    int idx;
    if (!ss0) begin
      if (sl_cnt == cfg_a) begin
        idx = int'(sl_frame[15:0]) & ((1 << (cfg_a - 1)) - 1);
        sl_rdata = sl_regs.exists(idx) ? sl_regs[idx] : 16'd0;
      end
      if (sl_cnt >= cfg_a && sl_cnt < cfg_a + cfg_dn)
        miso0 = sl_rdata[cfg_dn - 1 - (sl_cnt - cfg_a)];
    end
  end

  always @(posedge ss0) begin : slave_commit
    int          a;
    logic [31:0] dm;
    if (sl_cnt == cfg_a + cfg_dn && !sl_frame[cfg_a + cfg_dn - 1]) begin
      a  = int'(sl_frame >> cfg_dn) & ((1 << (cfg_a - 1)) - 1);
      dm = (32'd1 << cfg_dn) - 32'd1;
      sl_regs[a] = 16'(sl_frame & dm);
    end
  end

  // dut1 frame capture (miso1 tied high)
  logic [31:0] f1 = 32'd0;
  always @(negedge ss1) f1 = 32'd0;
  always @(posedge sck1) if (!ss1) f1 = {f1[30:0], mosi1};

  function automatic logic [15:0] reg_val(input int a);
    return sl_regs.exists(a) ? sl_regs[a] : 16'hDEAD;
  endfunction

  // One command on dut0 (sel=0) or dut1 (sel=1); call and return at a negedge.
  // Cycle numbers are relative to the accept edge (first sample after it = 1).
  task automatic do_txn(input bit sel, input logic rd, input logic [15:0] addr, input logic [15:0] dat,
                        input logic [4:0] ab, input logic [4:0] db, input int a_exp, input int dn_exp,
                        output int t_fall, output int t_rise, output int t_ready,
                        output int n_rsp, output int t_rsp, output logic [15:0] rsp_cap);
    int   guard;
    logic o_ss, o_rdy, o_rv;
    logic [15:0] o_rd;
    cmd_read = rd; cmd_addr = addr; cmd_data = dat; addr_bits = ab; data_bits = db;
    if (!sel) begin cfg_a = a_exp; cfg_dn = dn_exp; end
    if (sel) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
    guard = 0;
    while (!(sel ? cmd_ready1 : cmd_ready0) && guard < 1000) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    cmd_read = ~rd; cmd_addr = ~addr; cmd_data = ~dat; addr_bits = 5'd3; data_bits = 5'd3;
    t_fall = -1; t_rise = -1; t_ready = -1; n_rsp = 0; t_rsp = -1; rsp_cap = 16'd0;
    for (int rel = 1; rel < 1000; rel++) begin
      o_ss  = sel ? ss1 : ss0;
      o_rdy = sel ? cmd_ready1 : cmd_ready0;
      o_rv  = sel ? rsp_valid1 : rsp_valid0;
      o_rd  = sel ? rsp_data1 : rsp_data0;
      if (!o_ss && t_fall < 0) t_fall = rel;
      if (o_ss && t_fall >= 0 && t_rise < 0) t_rise = rel;
      if (o_rv) begin n_rsp++; t_rsp = rel; rsp_cap = o_rd; end
      if (o_rdy) begin t_ready = rel; break; end
      @(negedge clk);
    end
    checks++;
    if (t_ready < 0) begin errors++; $display("FAIL txn_timeout got ready=%0d want >0", t_ready); end
    $display("txn dut%0d rd=%0d addr=%h data=%h ss_fall=%0d ss_rise=%0d ready=%0d rsp=%0d@%0d %h",
             sel, rd, addr, dat, t_fall, t_rise, t_ready, n_rsp, t_rsp, rsp_cap);
  endtask

  task automatic test_reset;
    checks++; if (ss0 !== 1'b1)        begin errors++; $display("FAIL rst_ss got %b want 1", ss0); end
    checks++; if (sck0 !== 1'b0)       begin errors++; $display("FAIL rst_sck got %b want 0", sck0); end
    checks++; if (mosi0 !== 1'b0)      begin errors++; $display("FAIL rst_mosi got %b want 0", mosi0); end
    checks++; if (rsp_valid0 !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid0); end
    checks++; if (rsp_data0 !== 16'd0) begin errors++; $display("FAIL rst_rsp_data got %h want 0000", rsp_data0); end
    checks++; if (busy0 !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy0); end
    checks++; if (cmd_ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready0); end
  endtask

  task automatic test_write_8;
    int tf, tr, trdy, nr, trsp; logic [15:0] rc;
    do_txn(1'b0, 1'b0, 16'h0012, 16'h00A5, 5'd8, 5'd8, 8, 8, tf, tr, trdy, nr, trsp, rc);
    checks++; if (sl_frame !== 32'h0000_12A5) begin errors++; $display("FAIL wr8_mosi got %h want 000012a5", sl_frame); end
    checks++; if (reg_val(32'h12) !== 16'h00A5) begin errors++; $display("FAIL wr8_reg got %h want 00a5", reg_val(32'h12)); end
    checks++; if (nr !== 0)     begin errors++; $display("FAIL wr8_no_rsp got %0d want 0", nr); end
    checks++; if (tf !== 1)     begin errors++; $display("FAIL wr8_ss_fall got %0d want 1", tf); end
    checks++; if (tr !== 133)   begin errors++; $display("FAIL wr8_ss_rise got %0d want 133", tr); end
    checks++; if (trdy !== 137) begin errors++; $display("FAIL wr8_ready got %0d want 137", trdy); end
  endtask

  task automatic test_read_8;
    int tf, tr, trdy, nr, trsp; logic [15:0] rc;
    do_txn(1'b0, 1'b1, 16'h0012, 16'hFFFF, 5'd8, 5'd8, 8, 8, tf, tr, trdy, nr, trsp, rc);
    checks++; if (sl_frame !== 32'h0000_9200) begin errors++; $display("FAIL rd8_mosi got %h want 00009200", sl_frame); end
    checks++; if (nr !== 1)         begin errors++; $display("FAIL rd8_rsp_count got %0d want 1", nr); end
    checks++; if (trsp !== 133)     begin errors++; $display("FAIL rd8_rsp_cycle got %0d want 133", trsp); end
    checks++; if (rc !== 16'h00A5)  begin errors++; $display("FAIL rd8_rsp_data got %h want 00a5", rc); end
  endtask

  task automatic test_16_16;
    int tf, tr, trdy, nr, trsp; logic [15:0] rc;
    do_txn(1'b0, 1'b0, 16'h1234, 16'hBEEF, 5'd16, 5'd16, 16, 16, tf, tr, trdy, nr, trsp, rc);
    checks++; if (sl_frame !== 32'h1234_BEEF) begin errors++; $display("FAIL wr16_mosi got %h want 1234beef", sl_frame); end
    checks++; if (trdy !== 265) begin errors++; $display("FAIL wr16_ready got %0d want 265", trdy); end
    checks++; if (rsp_data0 !== 16'h00A5) begin errors++; $display("FAIL rsp_hold got %h want 00a5", rsp_data0); end
    do_txn(1'b0, 1'b1, 16'h1234, 16'h0000, 5'd16, 5'd16, 16, 16, tf, tr, trdy, nr, trsp, rc);
    checks++; if (sl_frame !== 32'h9234_0000) begin errors++; $display("FAIL rd16_mosi got %h want 92340000", sl_frame); end
    checks++; if (rc !== 16'hBEEF) begin errors++; $display("FAIL rd16_rsp_data got %h want beef", rc); end
    checks++; if (trsp !== 261)    begin errors++; $display("FAIL rd16_rsp_cycle got %0d want 261", trsp); end
  endtask

  task automatic test_back_to_back;
    int guard, t_rise, t_rdy, rel, rel2;
    cmd_read = 1'b0; cmd_addr = 16'h0021; cmd_data = 16'h003C; addr_bits = 5'd8; data_bits = 5'd8;
    cfg_a = 8; cfg_dn = 8;
    cmd_valid0 = 1'b1;
    guard = 0;
    while (!cmd_ready0 && guard < 1000) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_addr = 16'h0022; cmd_data = 16'h00C3;
    t_rise = -1; t_rdy = -1; rel = 1;
    while (rel < 1000) begin
      if (ss0 && t_rise < 0) t_rise = rel;
      if (cmd_ready0) begin t_rdy = rel; break; end
      @(negedge clk); rel++;
    end
    @(negedge clk);
    checks++; if (ss0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept got ss=%b busy=%b want ss=0 busy=1", ss0, busy0); end
    cmd_valid0 = 1'b0;
    checks++; if (t_rise !== 133) begin errors++; $display("FAIL b2b_ss_rise got %0d want 133", t_rise); end
    checks++; if (t_rdy !== 137)  begin errors++; $display("FAIL b2b_ready got %0d want 137", t_rdy); end
    rel2 = 1;
    while (!cmd_ready0 && rel2 < 1000) begin @(negedge clk); rel2++; end
    checks++; if (rel2 !== 137) begin errors++; $display("FAIL b2b_second_ready got %0d want 137", rel2); end
    checks++; if (reg_val(32'h21) !== 16'h003C) begin errors++; $display("FAIL b2b_reg21 got %h want 003c", reg_val(32'h21)); end
    checks++; if (reg_val(32'h22) !== 16'h00C3) begin errors++; $display("FAIL b2b_reg22 got %h want 00c3", reg_val(32'h22)); end
    $display("txn b2b first_ready=%0d second_ready=%0d", t_rdy, rel2);
  endtask

  task automatic test_reset_mid;
    int guard, bad, tf, tr, trdy, nr, trsp; logic [15:0] rc;
    cmd_read = 1'b0; cmd_addr = 16'h003C; cmd_data = 16'h005A; addr_bits = 5'd8; data_bits = 5'd8;
    cfg_a = 8; cfg_dn = 8;
    cmd_valid0 = 1'b1;
    guard = 0;
    while (!cmd_ready0 && guard < 1000) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid0 = 1'b0;
    guard = 0;
    while (!(sl_cnt == 5 && sck0) && guard < 500) begin @(negedge clk); guard++; end
    checks++; if (!(sl_cnt == 5 && sck0)) begin errors++; $display("FAIL rmid_reach got cnt=%0d want 5", sl_cnt); end
    checks++; if (mosi0 !== 1'b1) begin errors++; $display("FAIL rmid_pre_mosi got %b want 1", mosi0); end
    #2 reset = 1'b0;
    #1;
    checks++; if (ss0 !== 1'b1)        begin errors++; $display("FAIL rmid_ss got %b want 1", ss0); end
    checks++; if (sck0 !== 1'b0)       begin errors++; $display("FAIL rmid_sck got %b want 0", sck0); end
    checks++; if (mosi0 !== 1'b0)      begin errors++; $display("FAIL rmid_mosi got %b want 0", mosi0); end
    checks++; if (busy0 !== 1'b0)      begin errors++; $display("FAIL rmid_busy got %b want 0", busy0); end
    bad = 0;
    if (rsp_valid0) bad++;
    repeat (3) begin @(negedge clk); if (rsp_valid0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_no_rsp got %0d want 0", bad); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready0 !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", cmd_ready0); end
    $display("txn reset_mid applied");
    do_txn(1'b0, 1'b1, 16'h0012, 16'h0000, 5'd8, 5'd8, 8, 8, tf, tr, trdy, nr, trsp, rc);
    checks++; if (rc !== 16'h00A5 || nr !== 1) begin errors++; $display("FAIL rmid_readback got %h x%0d want 00a5 x1", rc, nr); end
  endtask

  task automatic test_d1_clamp;
    int tf, tr, trdy, nr, trsp; logic [15:0] rc;
    do_txn(1'b1, 1'b0, 16'h0001, 16'h0001, 5'd1, 5'd0, 2, 1, tf, tr, trdy, nr, trsp, rc);
    checks++; if (f1 !== 32'd3)  begin errors++; $display("FAIL d1_wr_mosi got %h want 00000003", f1); end
    checks++; if (tf !== 1)      begin errors++; $display("FAIL d1_ss_fall got %0d want 1", tf); end
    checks++; if (tr !== 8)      begin errors++; $display("FAIL d1_ss_rise got %0d want 8", tr); end
    checks++; if (trdy !== 12)   begin errors++; $display("FAIL d1_ready got %0d want 12", trdy); end
    checks++; if (nr !== 0)      begin errors++; $display("FAIL d1_wr_no_rsp got %0d want 0", nr); end
    do_txn(1'b1, 1'b1, 16'h0001, 16'h0000, 5'd1, 5'd0, 2, 1, tf, tr, trdy, nr, trsp, rc);
    checks++; if (f1 !== 32'd6)      begin errors++; $display("FAIL d1_rd_mosi got %h want 00000006", f1); end
    checks++; if (trsp !== 8)        begin errors++; $display("FAIL d1_rsp_cycle got %0d want 8", trsp); end
    checks++; if (rc !== 16'h0001)   begin errors++; $display("FAIL d1_rsp_data got %h want 0001", rc); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_write_8();
    test_read_8();
    test_16_16();
    test_back_to_back();
    test_reset_mid();
    test_d1_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
